// File: rtl/micro_tile_scanner_if.sv
// Host-side bundle between the tile self-test sequencer and the micro-tile
// container: scan control, tile select/reset/stimulus, tile response and the
// indexed signature read port.
interface micro_tile_scanner_if #(
    parameter int SEL_W = 2
);
    logic             start;
    logic             busy;
    logic             done;
    logic [SEL_W-1:0] sel;
    logic             tile_rst_n;
    logic [7:0]       tile_ui_in;
    logic [7:0]       tile_uo_out;
    logic [SEL_W-1:0] rd_idx;
    logic [15:0]      rd_sig;

    // The scanner drives select, reset and stimulus and owns the signatures
    modport master (
        input  start,
        input  tile_uo_out,
        input  rd_idx,
        output busy,
        output done,
        output sel,
        output tile_rst_n,
        output tile_ui_in,
        output rd_sig
    );

    // Host / container side of the same bundle
    modport slave (
        output start,
        output tile_uo_out,
        output rd_idx,
        input  busy,
        input  done,
        input  sel,
        input  tile_rst_n,
        input  tile_ui_in,
        input  rd_sig
    );
endinterface

// File: rtl/micro_tile_scanner.sv
// Self-test sequencer for the micro-tile container. On start it walks every
// tile: holds it in reset, then drives a counting stimulus while folding the
// tile's responses into a 16-bit MISR. One signature is kept per tile and is
// readable combinationally through an indexed port.
module micro_tile_scanner #(
    parameter int NUM_TILES    = 4,
    parameter int SEL_W        = 2,
    parameter int RESET_CYCLES = 4,
    parameter int RUN_CYCLES   = 16
) (
    input logic                 clk,
    input logic                 rst,
    micro_tile_scanner_if.master bus
);

    // One counter serves both the reset hold and the run phase, so it is
    // sized for whichever phase is longer.
    localparam int CNT_MAX = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_TILE   = SEL_W'(NUM_TILES - 1);
    localparam logic [SEL_W:0]   TILE_COUNT  = (SEL_W + 1)'(NUM_TILES);
    localparam logic [15:0]      MISR_SEED   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state, state_nx;
    logic [SEL_W-1:0] sel_q, sel_nx;
    logic             tile_rst_n_q, tile_rst_n_nx;
    logic [7:0]       tile_ui_in_q, tile_ui_in_nx;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [15:0]      misr, misr_nx, misr_step;
    logic             sig_we;
    logic [15:0]      sig_mem [NUM_TILES];

    // Next-state and next-output decode; every output is registered, so this
    // block computes the value each register takes at the coming edge.
    always_comb begin
        state_nx      = state;
        sel_nx        = sel_q;
        tile_rst_n_nx = tile_rst_n_q;
        tile_ui_in_nx = tile_ui_in_q;
        busy_nx       = busy_q;
        done_nx       = 1'b0;
        cnt_nx        = cnt;
        misr_nx       = misr;
        sig_we        = 1'b0;
        misr_step     = {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]}
                        ^ {8'h00, bus.tile_uo_out};

        case (state)
            ST_IDLE: begin
                sel_nx        = '0;
                tile_rst_n_nx = 1'b0;
                tile_ui_in_nx = 8'h00;
                busy_nx       = 1'b0;
                if (bus.start) begin
                    state_nx = ST_RESET;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                end
            end

            ST_RESET: begin
                tile_rst_n_nx = 1'b0;
                tile_ui_in_nx = 8'h00;
                if (cnt == RESET_LAST) begin
                    state_nx      = ST_RUN;
                    cnt_nx        = '0;
                    misr_nx       = MISR_SEED;
                    tile_rst_n_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            ST_RUN: begin
                misr_nx = misr_step;
                if (cnt == RUN_LAST) begin
                    sig_we        = 1'b1;
                    cnt_nx        = '0;
                    tile_rst_n_nx = 1'b0;
                    tile_ui_in_nx = 8'h00;
                    if (sel_q < LAST_TILE) begin
                        sel_nx   = sel_q + 1'b1;
                        state_nx = ST_RESET;
                    end else begin
                        state_nx = ST_DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end else begin
                    cnt_nx        = cnt + 1'b1;
                    tile_ui_in_nx = 8'(cnt_nx);
                end
            end

            ST_DONE: begin
                state_nx      = ST_IDLE;
                sel_nx        = '0;
                tile_rst_n_nx = 1'b0;
                tile_ui_in_nx = 8'h00;
                busy_nx       = 1'b0;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, counter, MISR and output registers; reset returns to an idle,
    // quiescent host side with the MISR at its seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            sel_q        <= '0;
            tile_rst_n_q <= 1'b0;
            tile_ui_in_q <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt          <= '0;
            misr         <= MISR_SEED;
        end else begin
            state        <= state_nx;
            sel_q        <= sel_nx;
            tile_rst_n_q <= tile_rst_n_nx;
            tile_ui_in_q <= tile_ui_in_nx;
            busy_q       <= busy_nx;
            done_q       <= done_nx;
            cnt          <= cnt_nx;
            misr         <= misr_nx;
        end
    end

    // Signature store: a tile's entry is replaced only when its run completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TILES; i++) begin
                sig_mem[i] <= 16'h0000;
            end
        end else if (sig_we) begin
            sig_mem[sel_q] <= misr_nx;
        end
    end

    // Combinational read port; indices beyond the last tile read as zero.
    always_comb begin
        bus.rd_sig = 16'h0000;
        if ({1'b0, bus.rd_idx} < TILE_COUNT) begin
            bus.rd_sig = sig_mem[bus.rd_idx];
        end
    end

    assign bus.sel        = sel_q;
    assign bus.tile_rst_n = tile_rst_n_q;
    assign bus.tile_ui_in = tile_ui_in_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_micro_tile_scanner.sv
// Directed bench for micro_tile_scanner: a 4-tile instance for timing,
// signature and reset scenarios, and a 3-tile instance for the read-port sweep.
module tb_micro_tile_scanner;

    logic clk = 1'b0;
    logic rst;
    logic tile_mode;
    int   tests_run    = 0;
    int   tests_failed = 0;

    micro_tile_scanner_if #(.SEL_W(2)) bus0 ();
    micro_tile_scanner_if #(.SEL_W(2)) bus1 ();

    micro_tile_scanner #(
        .NUM_TILES(4), .SEL_W(2), .RESET_CYCLES(4), .RUN_CYCLES(16)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    micro_tile_scanner #(
        .NUM_TILES(3), .SEL_W(2), .RESET_CYCLES(4), .RUN_CYCLES(16)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Tile models: all-zero responder, or uo_out = ui_in ^ tile index
    always_comb bus0.tile_uo_out = tile_mode ? (bus0.tile_ui_in ^ {6'b0, bus0.sel}) : 8'h00;
    always_comb bus1.tile_uo_out = tile_mode ? (bus1.tile_ui_in ^ {6'b0, bus1.sel}) : 8'h00;

    // Golden MISR of one 16-cycle run: data k ^ tile, taps 15/13/12/10, seed FFFF
    function automatic logic [15:0] misr_ref(input logic [7:0] tile);
        logic [15:0] m;
        m = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            m = {m[14:0], ^(m & 16'hB400)} ^ {8'h00, 8'(k) ^ tile};
        end
        return m;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus0.start  = 1'($urandom_range(0, 1));
        bus1.start  = 1'($urandom_range(0, 1));
        bus0.rd_idx = 2'($urandom_range(0, 3));
        tile_mode   = 1'($urandom_range(0, 1));
        repeat (3) tick();
        tests_run++;
        if ({bus0.sel, bus0.tile_rst_n, bus0.tile_ui_in, bus0.busy, bus0.done} !== 13'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got sel=%0h rst_n=%0b ui=%0h busy=%0b done=%0b, expected all 0",
                     bus0.sel, bus0.tile_rst_n, bus0.tile_ui_in, bus0.busy, bus0.done);
        end
        for (int i = 0; i < 4; i++) begin
            bus0.rd_idx = 2'(i);
            bus1.rd_idx = 2'(i);
            #1;
            tests_run++;
            if (bus0.rd_sig !== 16'h0000 || bus1.rd_sig !== 16'h0000) begin
                tests_failed++;
                $display("[TB] FAIL reset_rd_sig[%0d]: got %h/%h expected 0000", i, bus0.rd_sig, bus1.rd_sig);
            end
        end
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_scan;
        logic        exp_busy, exp_done;
        logic [15:0] s0;
        tile_mode  = 1'b0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int c = 1; c <= 90; c++) begin
            exp_busy = (c <= 80);
            exp_done = (c == 81);
            tests_run++;
            if ({bus0.busy, bus0.done} !== {exp_busy, exp_done}) begin
                tests_failed++;
                $display("[TB] FAIL zero_busy_done cycle %0d: got busy=%0b done=%0b expected %0b/%0b",
                         c, bus0.busy, bus0.done, exp_busy, exp_done);
            end
            tick();
        end
        bus0.rd_idx = 2'd0;
        #1;
        s0 = bus0.rd_sig;
        for (int i = 0; i < 4; i++) begin
            bus0.rd_idx = 2'(i);
            #1;
            tests_run++;
            if (bus0.rd_sig !== 16'h001B) begin
                tests_failed++;
                $display("[TB] FAIL zero_sig[%0d]: got %h expected 001b", i, bus0.rd_sig);
            end
            tests_run++;
            if (bus0.rd_sig !== s0) begin
                tests_failed++;
                $display("[TB] FAIL zero_sig_equal[%0d]: got %h expected %h", i, bus0.rd_sig, s0);
            end
        end
    endtask

    task automatic test_per_tile;
        int          t, pos;
        logic        exp_rst_n;
        logic [7:0]  exp_ui;
        logic [15:0] sig [4];
        tile_mode  = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int c = 1; c <= 81; c++) begin
            if (c <= 80) begin
                t         = (c - 1) / 20;
                pos       = (c - 1) % 20;
                exp_rst_n = (pos >= 4);
                exp_ui    = exp_rst_n ? 8'(pos - 4) : 8'h00;
                tests_run++;
                if ({bus0.sel, bus0.tile_rst_n, bus0.tile_ui_in} !== {2'(t), exp_rst_n, exp_ui}) begin
                    tests_failed++;
                    $display("[TB] FAIL tile_drive cycle %0d: got sel=%0d rst_n=%0b ui=%0d expected %0d/%0b/%0d",
                             c, bus0.sel, bus0.tile_rst_n, bus0.tile_ui_in, t, exp_rst_n, exp_ui);
                end
            end else begin
                tests_run++;
                if (bus0.done !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL tile_done: got %0b expected 1", bus0.done);
                end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            bus0.rd_idx = 2'(i);
            #1;
            sig[i] = bus0.rd_sig;
            tests_run++;
            if (sig[i] !== misr_ref(8'(i))) begin
                tests_failed++;
                $display("[TB] FAIL tile_sig[%0d]: got %h expected %h", i, sig[i], misr_ref(8'(i)));
            end
        end
        for (int i = 1; i < 4; i++) begin
            for (int j = 0; j < i; j++) begin
                tests_run++;
                if (sig[i] === sig[j]) begin
                    tests_failed++;
                    $display("[TB] FAIL tile_sig_distinct[%0d,%0d]: got %h and %h, expected different", i, j, sig[i], sig[j]);
                end
            end
        end
    endtask

    task automatic test_protocol;
        logic [1:0] prev_sel;
        int         low_cnt, rises, done_cycle, extra_done;
        low_cnt = 0; rises = 0; done_cycle = -1; extra_done = 0;
        tile_mode  = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        prev_sel = bus0.sel;
        for (int c = 1; c <= 90; c++) begin
            bus0.start = (c == 10 || c == 37 || c == 60);
            if (bus0.sel !== prev_sel) begin
                tests_run++;
                if (bus0.tile_rst_n !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL sel_while_running cycle %0d: got rst_n=%0b expected 0", c, bus0.tile_rst_n);
                end
            end
            if (bus0.tile_rst_n === 1'b1) begin
                if (low_cnt != 0) begin
                    rises++;
                    tests_run++;
                    if (low_cnt != 4) begin
                        tests_failed++;
                        $display("[TB] FAIL reset_len cycle %0d: got %0d expected 4", c, low_cnt);
                    end
                end
                low_cnt = 0;
            end else if (bus0.busy === 1'b1) begin
                low_cnt++;
            end
            if (bus0.done === 1'b1) begin
                if (done_cycle < 0) done_cycle = c;
                else extra_done++;
            end
            prev_sel = bus0.sel;
            tick();
        end
        bus0.start = 1'b0;
        tests_run++;
        if (rises != 4) begin
            tests_failed++;
            $display("[TB] FAIL run_count: got %0d expected 4", rises);
        end
        tests_run++;
        if (done_cycle != 81 || extra_done != 0) begin
            tests_failed++;
            $display("[TB] FAIL start_during_busy: got done at %0d (+%0d extra) expected 81", done_cycle, extra_done);
        end
    endtask

    task automatic test_reset_midscan;
        tile_mode   = 1'b1;
        bus0.rd_idx = 2'd0;
        bus0.start  = 1'b1;
        tick();
        bus0.start  = 1'b0;
        repeat (29) tick();
        tests_run++;
        if ({bus0.sel, bus0.tile_rst_n} !== 3'b011 || bus0.rd_sig !== misr_ref(8'd0)) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_state: got sel=%0d rst_n=%0b sig0=%h expected 1/1/%h",
                     bus0.sel, bus0.tile_rst_n, bus0.rd_sig, misr_ref(8'd0));
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus0.sel, bus0.tile_rst_n, bus0.tile_ui_in, bus0.busy, bus0.done} !== 13'h0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_outputs: got sel=%0h rst_n=%0b ui=%0h busy=%0b done=%0b expected all 0",
                     bus0.sel, bus0.tile_rst_n, bus0.tile_ui_in, bus0.busy, bus0.done);
        end
        tests_run++;
        if (bus0.rd_sig !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_sig0: got %h expected 0000", bus0.rd_sig);
        end
        #1;
        rst = 1'b0;
        repeat (5) tick();
        tests_run++;
        if ({bus0.busy, bus0.tile_rst_n} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL no_resume: got busy=%0b rst_n=%0b expected 0/0", bus0.busy, bus0.tile_rst_n);
        end
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int c = 1; c <= 81; c++) begin
            if (c <= 20) begin
                tests_run++;
                if (bus0.rd_sig !== 16'h0000) begin
                    tests_failed++;
                    $display("[TB] FAIL rerun_sig0_early cycle %0d: got %h expected 0000", c, bus0.rd_sig);
                end
            end else if (c == 21) begin
                tests_run++;
                if (bus0.rd_sig !== misr_ref(8'd0)) begin
                    tests_failed++;
                    $display("[TB] FAIL rerun_sig0_ready: got %h expected %h", bus0.rd_sig, misr_ref(8'd0));
                end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            bus0.rd_idx = 2'(i);
            #1;
            tests_run++;
            if (bus0.rd_sig !== misr_ref(8'(i))) begin
                tests_failed++;
                $display("[TB] FAIL rerun_sig[%0d]: got %h expected %h", i, bus0.rd_sig, misr_ref(8'(i)));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic exp_busy, exp_done;
        tile_mode  = 1'b0;
        bus0.start = 1'b1;
        tick();
        for (int c = 1; c <= 170; c++) begin
            if (c == 164) bus0.start = 1'b0;
            exp_busy = (c <= 80) || (c >= 83 && c <= 162);
            exp_done = (c == 81) || (c == 163);
            tests_run++;
            if ({bus0.busy, bus0.done} !== {exp_busy, exp_done}) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back cycle %0d: got busy=%0b done=%0b expected %0b/%0b",
                         c, bus0.busy, bus0.done, exp_busy, exp_done);
            end
            tick();
        end
    endtask

    task automatic test_rd_sweep;
        logic [15:0] exp_sig;
        tile_mode  = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            tests_run++;
            if (bus1.done !== (c == 61)) begin
                tests_failed++;
                $display("[TB] FAIL three_tile_done cycle %0d: got %0b expected %0b", c, bus1.done, (c == 61));
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            bus1.rd_idx = 2'(i);
            #1;
            exp_sig = (i < 3) ? misr_ref(8'(i)) : 16'h0000;
            tests_run++;
            if (bus1.rd_sig !== exp_sig) begin
                tests_failed++;
                $display("[TB] FAIL rd_sweep[%0d]: got %h expected %h", i, bus1.rd_sig, exp_sig);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        rst         = 1'b1;
        tile_mode   = 1'b0;
        bus0.start  = 1'b0;
        bus1.start  = 1'b0;
        bus0.rd_idx = 2'd0;
        bus1.rd_idx = 2'd0;
        test_reset();
        test_zero_scan();
        test_per_tile();
        test_protocol();
        test_reset_midscan();
        test_back_to_back();
        test_rd_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/micro_tile_scanner.md
# micro_tile_scanner

Self-test sequencer for the micro-tile container; it sits on the host side of the tile select/reset/stimulus interface. On `start` it selects each tile in turn, holds it in reset, then drives a deterministic stimulus while compressing the tile's `uo_out` responses into a 16-bit MISR signature. Signatures are kept per tile and read back through an indexed port. Its outputs drive the container's select, reset and input pins; its `tile_uo_out` input is the container's muxed output.

## Interface
Parameters:
- `NUM_TILES`, default 4: number of tiles scanned, indices 0..NUM_TILES-1.
- `SEL_W`, default 2: width of the select and index buses; must satisfy 2^SEL_W >= NUM_TILES.
- `RESET_CYCLES`, default 4: number of cycles each tile is held in reset; must be >= 1.
- `RUN_CYCLES`, default 16: number of stimulus/capture cycles per tile; must be between 1 and 256.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: requests a scan; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until DONE.
- `done` out 1: one-cycle pulse when the last tile completes.
- `sel` out SEL_W: tile select, driven to the container select pins.
- `tile_rst_n` out 1: active-low reset to the selected tile.
- `tile_ui_in` out 8: stimulus to the selected tile.
- `tile_uo_out` in 8: response from the selected tile.
- `rd_idx` in SEL_W: index of the signature to read.
- `rd_sig` out 16: stored signature for `rd_idx`.

## Operation
- FSM states are IDLE, RESET, RUN and DONE. All outputs except `rd_sig` are registered.
- IDLE:
  - `sel`=0, `tile_rst_n`=0, `tile_ui_in`=0, `busy`=0.
  - `start`=1 → RESET, with `sel`=0 and the cycle counter at 0.
- RESET:
  - `tile_rst_n`=0, `tile_ui_in`=0.
  - Lasts exactly RESET_CYCLES cycles, then → RUN.
  - On entry to RUN the MISR is seeded to 16'hFFFF and the run counter `k` to 0.
- RUN:
  - `tile_rst_n`=1, `tile_ui_in`=k[7:0].
  - Each cycle: MISR ← {m[14:0], m[15]^m[13]^m[12]^m[10]} ^ {8'h00, tile_uo_out}, sampling `tile_uo_out` in that same cycle; then k ← k+1.
  - After the cycle with k=RUN_CYCLES-1, the post-update MISR value is written to sig_mem[sel].
  - If sel < NUM_TILES-1: `sel`←sel+1, `tile_rst_n`←0, → RESET.
  - Otherwise → DONE.
- DONE: `done`=1 and `busy`=0 for one cycle, then → IDLE (`sel`←0).
- `sel` changes only in cycles where `tile_rst_n`=0, i.e. never while a tile is running.
- `start` is ignored in RESET, RUN and DONE. `start` held high continuously restarts a scan from IDLE on every pass.
- `rd_sig` is combinational: sig_mem[rd_idx], or 16'h0000 if rd_idx >= NUM_TILES. Entries not yet written read 0.
- A new scan overwrites each entry only when that tile completes. Entries from a previous scan stay readable until then.

## Timing
- Reset values: state=IDLE, `sel`=0, `tile_rst_n`=0, `tile_ui_in`=0, `busy`=0, `done`=0, MISR=16'hFFFF, all sig_mem entries=0.
- `rst` asserted mid-scan: all of the above apply immediately (asynchronous). No partial signature is written, and the scan is not resumed.
- Cycle 0 is the edge that samples `start`=1:
  - `busy`=1 from cycle 1.
  - Tile t is in reset for cycles 1+t·P .. t·P+RESET_CYCLES, where P = RESET_CYCLES+RUN_CYCLES.
  - Tile t runs for the following RUN_CYCLES cycles.
- `done` is high at cycle NUM_TILES·P+1. With defaults that is cycle 81.
- sig_mem[t] becomes readable on `rd_sig` in the cycle after tile t's last RUN cycle.
- Tile-to-tile turnaround adds no idle cycles: the cycle after a tile's last RUN cycle is the first RESET cycle of the next tile.

## Test plan
- Reset: assert `rst` with random inputs → `sel`=0, `tile_rst_n`=0, `tile_ui_in`=0, `busy`=0, `done`=0, `rd_sig`=0 for every `rd_idx`.
- Default scan, tile model `tile_uo_out`=0 → `busy` high on cycles 1..80 and `done` pulses only on cycle 81. All four sig_mem entries equal the golden MISR of 16 zero inputs from seed FFFF, and are identical to each other.
- Per-tile models (tile t: uo_out = ui_in ^ t, driven combinationally from `sel`) → sig_mem[0..3] equal golden model values and are pairwise distinct. `tile_ui_in` steps 0..15 in every RUN phase.
- Protocol check → `sel` never changes while `tile_rst_n`=1. `tile_rst_n` is low for exactly 4 cycles before each run. `start` pulses during `busy` do not alter timing.
- Assert `rst` at cycle 30 (tile 1 running), then rerun the scan → `rd_sig` for index 0 reads 0 until cycle 21 of the new scan. The final signatures match the clean-scan results.
- `rd_idx` sweep after a scan with NUM_TILES=3, SEL_W=2 → index 3 reads 16'h0000; indices 0..2 read their golden values.
